// File: rtl/branch_pkg.sv
// Shared types and constants for branch prediction tracking and resolution.
package branch_pkg;

    localparam int ADDR_W = 32;
    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;
    localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] branchAddr;
        logic [ADDR_W-1:0] targetAddr;
        logic              direction;
        logic              prediction;
    } branch_info_t;

    typedef enum logic {
        TRACK   = 1'b0,
        RECOVER = 1'b1
    } state_t;

endpackage

// File: rtl/branch_info_fifo.sv
// Circular buffer of in-flight branch predictions, oldest entry at the head.
import branch_pkg::*;

module branch_info_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  branch_info_t               wr_data,
    output branch_info_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);

    branch_info_t   entry_reg [DEPTH];
    logic [PW-1:0]  head_reg;
    logic [PW-1:0]  tail_reg;
    logic [PW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = entry_reg[head_reg];
    // A pop in the same cycle frees a slot, so a push into a full buffer is safe then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            entry_reg[tail_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) tail_reg <= tail_reg + PW'(1);
            if (do_pop)  head_reg <= head_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves in-order branch predictions against execute outcomes and drives
// flush, PC redirect and predictor counter updates.
import branch_pkg::*;

module branch_resolve_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    input  logic                  pred_taken,
    input  logic                  pred_dir,
    input  logic [DATA_WIDTH-1:0] pred_pc,
    input  logic [DATA_WIDTH-1:0] pred_target,
    input  logic                  stallF,
    input  logic                  BranchE,
    input  logic                  ZeroE,
    output logic                  full,
    output logic                  flushBranch,
    output logic                  PCBPUSrc,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  upd_valid,
    output logic                  upd_dir,
    output logic                  upd_inc,
    output logic                  underflow_err
);

    localparam int PW = $clog2(DEPTH);

    state_t                state_reg, state_next;
    branch_info_t          head;
    branch_info_t          wr_data;
    logic [PW:0]           count;
    logic                  fifo_full, fifo_empty;
    logic                  resolve, mispredict, push;
    logic                  flush_reg, flush_next;
    logic                  pcsrc_reg, pcsrc_next;
    logic                  upd_valid_reg, upd_valid_next;
    logic                  upd_dir_reg, upd_dir_next;
    logic                  upd_inc_reg, upd_inc_next;
    logic                  underflow_reg, underflow_next;
    logic [DATA_WIDTH-1:0] redirect_reg, redirect_next;

    assign wr_data = '{branchAddr: ADDR_W'(pred_pc),
                       targetAddr: ADDR_W'(pred_target),
                       direction:  pred_dir,
                       prediction: pred_taken};

    branch_info_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (resolve),
        .clear   (mispredict),
        .wr_data (wr_data),
        .head    (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_next     = state_reg;
        resolve        = 1'b0;
        mispredict     = 1'b0;
        push           = 1'b0;
        flush_next     = 1'b0;
        pcsrc_next     = 1'b0;
        upd_valid_next = 1'b0;
        upd_dir_next   = 1'b0;
        upd_inc_next   = 1'b0;
        underflow_next = underflow_reg;
        redirect_next  = redirect_reg;
        case (state_reg)
            TRACK: begin
                if (BranchE) begin
                    if (fifo_empty) begin
                        underflow_next = 1'b1;
                    end else begin
                        resolve        = 1'b1;
                        upd_valid_next = 1'b1;
                        upd_dir_next   = head.direction;
                        upd_inc_next   = (head.prediction == ZeroE);
                        if (head.prediction != ZeroE) begin
                            mispredict    = 1'b1;
                            flush_next    = 1'b1;
                            pcsrc_next    = 1'b1;
                            state_next    = RECOVER;
                            redirect_next = DATA_WIDTH'(ZeroE ? head.targetAddr
                                                              : head.branchAddr + PC_INC);
                        end
                    end
                end
                // Fetch alongside a mispredict is wrong-path and is discarded.
                push = pred_valid && !stallF && (!fifo_full || resolve) && !mispredict;
            end
            RECOVER: begin
                state_next = TRACK;
            end
            default: begin
                state_next = TRACK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= TRACK;
            flush_reg     <= 1'b0;
            pcsrc_reg     <= 1'b0;
            upd_valid_reg <= 1'b0;
            upd_dir_reg   <= 1'b0;
            upd_inc_reg   <= 1'b0;
            underflow_reg <= 1'b0;
            redirect_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            flush_reg     <= flush_next;
            pcsrc_reg     <= pcsrc_next;
            upd_valid_reg <= upd_valid_next;
            upd_dir_reg   <= upd_dir_next;
            upd_inc_reg   <= upd_inc_next;
            underflow_reg <= underflow_next;
            redirect_reg  <= redirect_next;
        end
    end

    assign full          = fifo_full;
    assign flushBranch   = flush_reg;
    assign PCBPUSrc      = pcsrc_reg;
    assign redirect_pc   = redirect_reg;
    assign upd_valid     = upd_valid_reg;
    assign upd_dir       = upd_dir_reg;
    assign upd_inc       = upd_inc_reg;
    assign underflow_err = underflow_reg;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Table-driven scoreboard bench for branch_resolve_ctrl (DATA_WIDTH=32, DEPTH=4).
import branch_pkg::*;

module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_valid = 1'b0, pred_taken = 1'b0, pred_dir = 1'b0;
    logic [31:0] pred_pc = '0, pred_target = '0;
    logic        stallF = 1'b0, BranchE = 1'b0, ZeroE = 1'b0;
    logic        full, flushBranch, PCBPUSrc, upd_valid, upd_dir, upd_inc, underflow_err;
    logic [31:0] redirect_pc;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        r, pv, st, tk, dr;
        logic [31:0] pc, tg;
        logic        be, zr;
        logic [4:0]  ex;   // {upd_valid, upd_dir, upd_inc, flushBranch, PCBPUSrc}
        logic [31:0] rd;
        logic [2:0]  cn;
        logic        uf, rc;
    } stim_t;

    stim_t exp_q[$];

    branch_resolve_ctrl #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_dir(pred_dir), .pred_pc(pred_pc), .pred_target(pred_target),
        .stallF(stallF), .BranchE(BranchE), .ZeroE(ZeroE), .full(full),
        .flushBranch(flushBranch), .PCBPUSrc(PCBPUSrc), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_dir(upd_dir), .upd_inc(upd_inc),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic r, pv, st, tk, dr,
                                 input logic [31:0] pc, tg,
                                 input logic be, zr,
                                 input logic [4:0] ex,
                                 input logic [31:0] rd,
                                 input logic [2:0] cn,
                                 input logic uf, rc);
        stim_t s;
        s.r = r; s.pv = pv; s.st = st; s.tk = tk; s.dr = dr; s.pc = pc; s.tg = tg;
        s.be = be; s.zr = zr; s.ex = ex; s.rd = rd; s.cn = cn; s.uf = uf; s.rc = rc;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rst = s.r; pred_valid = s.pv; stallF = s.st; pred_taken = s.tk; pred_dir = s.dr;
        pred_pc = s.pc; pred_target = s.tg; BranchE = s.be; ZeroE = s.zr;
        exp_q.push_back(s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t tbl[$];
        stim_t e;
        tbl.push_back(mk(1,1,0,1,1,32'h10,32'h20,1,1,5'b00000,32'h0,3'd0,0,0));
        tbl.push_back(mk(1,0,0,0,0,32'h0,32'h0,0,0,5'b00000,32'h0,3'd0,0,0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            tick();
            e = exp_q.pop_front();
            n_assert++;
            if ({upd_valid,upd_dir,upd_inc,flushBranch,PCBPUSrc} !== e.ex) begin
                n_fail++; $display("FAIL reset[%0d] strobes got %b expected %b", i, {upd_valid,upd_dir,upd_inc,flushBranch,PCBPUSrc}, e.ex);
            end
            n_assert++;
            if (redirect_pc !== e.rd || underflow_err !== e.uf || full !== 1'b0) begin
                n_fail++; $display("FAIL reset[%0d] redirect/underflow/full got %h/%b/%b expected %h/%b/0", i, redirect_pc, underflow_err, full, e.rd, e.uf);
            end
            n_assert++;
            if (dut.count !== e.cn || (dut.state_reg == RECOVER) !== e.rc) begin
                n_fail++; $display("FAIL reset[%0d] count/recover got %0d/%b expected %0d/%b", i, dut.count, dut.state_reg == RECOVER, e.cn, e.rc);
            end
        end
    endtask

    task automatic test_correct_and_mispredict();
        stim_t tbl[$];
        stim_t e;
        tbl.push_back(mk(0,1,0,1,1,32'h100,32'h80,0,0,5'b00000,32'h0,3'd1,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,0,0,5'b00000,32'h0,3'd1,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,1,1,5'b11100,32'h0,3'd0,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,0,0,5'b00000,32'h0,3'd0,0,0));
        tbl.push_back(mk(0,1,0,0,0,32'h200,32'h240,0,0,5'b00000,32'h0,3'd1,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,1,1,5'b10011,32'h240,3'd0,0,1));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,0,0,5'b00000,32'h0,3'd0,0,0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            tick();
            e = exp_q.pop_front();
            n_assert++;
            if ({upd_valid,upd_dir,upd_inc,flushBranch,PCBPUSrc} !== e.ex) begin
                n_fail++; $display("FAIL resolve[%0d] strobes got %b expected %b", i, {upd_valid,upd_dir,upd_inc,flushBranch,PCBPUSrc}, e.ex);
            end
            if (e.ex[0]) begin
                n_assert++;
                if (redirect_pc !== e.rd) begin
                    n_fail++; $display("FAIL resolve[%0d] redirect_pc got %h expected %h", i, redirect_pc, e.rd);
                end
            end
            n_assert++;
            if (dut.count !== e.cn || full !== (e.cn == 3'd4) || underflow_err !== e.uf) begin
                n_fail++; $display("FAIL resolve[%0d] count/full/underflow got %0d/%b/%b expected %0d/%b", i, dut.count, full, underflow_err, e.cn, e.uf);
            end
            n_assert++;
            if ((dut.state_reg == RECOVER) !== e.rc) begin
                n_fail++; $display("FAIL resolve[%0d] recover state got %b expected %b", i, dut.state_reg == RECOVER, e.rc);
            end
        end
    endtask

    task automatic test_flush_queue();
        stim_t tbl[$];
        stim_t e;
        tbl.push_back(mk(0,1,0,1,0,32'h300,32'h2F0,0,0,5'b00000,32'h0,3'd1,0,0));
        tbl.push_back(mk(0,1,0,0,1,32'h400,32'h500,0,0,5'b00000,32'h0,3'd2,0,0));
        tbl.push_back(mk(0,1,0,1,1,32'h600,32'h610,1,0,5'b10011,32'h304,3'd0,0,1));
        tbl.push_back(mk(0,1,0,1,1,32'h700,32'h710,1,0,5'b00000,32'h0,3'd0,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,0,0,5'b00000,32'h0,3'd0,0,0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            tick();
            e = exp_q.pop_front();
            n_assert++;
            if ({upd_valid,upd_dir,upd_inc,flushBranch,PCBPUSrc} !== e.ex) begin
                n_fail++; $display("FAIL flush_queue[%0d] strobes got %b expected %b", i, {upd_valid,upd_dir,upd_inc,flushBranch,PCBPUSrc}, e.ex);
            end
            if (e.ex[0]) begin
                n_assert++;
                if (redirect_pc !== e.rd) begin
                    n_fail++; $display("FAIL flush_queue[%0d] redirect_pc got %h expected %h", i, redirect_pc, e.rd);
                end
            end
            n_assert++;
            if (dut.count !== e.cn || underflow_err !== e.uf || (dut.state_reg == RECOVER) !== e.rc) begin
                n_fail++; $display("FAIL flush_queue[%0d] count/underflow/recover got %0d/%b/%b expected %0d/%b/%b", i, dut.count, underflow_err, dut.state_reg == RECOVER, e.cn, e.uf, e.rc);
            end
        end
    endtask

    task automatic test_full_back_to_back();
        stim_t tbl[$];
        stim_t e;
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(0,1,0,1,k[0],32'h1000+32'(16*k),32'h2000+32'(16*k),0,0,5'b00000,32'h0,3'(k+1),0,0));
        end
        tbl.push_back(mk(0,1,0,0,1,32'h1040,32'h9990,0,0,5'b00000,32'h0,3'd4,0,0));
        tbl.push_back(mk(0,1,0,0,1,32'h5000,32'h5800,1,1,5'b10100,32'h0,3'd4,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,1,1,5'b11100,32'h0,3'd3,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,1,1,5'b10100,32'h0,3'd2,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,1,1,5'b11100,32'h0,3'd1,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,1,1,5'b11011,32'h5800,3'd0,0,1));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,0,0,5'b00000,32'h0,3'd0,0,0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            tick();
            e = exp_q.pop_front();
            n_assert++;
            if ({upd_valid,upd_dir,upd_inc,flushBranch,PCBPUSrc} !== e.ex) begin
                n_fail++; $display("FAIL full[%0d] strobes got %b expected %b", i, {upd_valid,upd_dir,upd_inc,flushBranch,PCBPUSrc}, e.ex);
            end
            if (e.ex[0]) begin
                n_assert++;
                if (redirect_pc !== e.rd) begin
                    n_fail++; $display("FAIL full[%0d] redirect_pc got %h expected %h", i, redirect_pc, e.rd);
                end
            end
            n_assert++;
            if (full !== (e.cn == 3'd4)) begin
                n_fail++; $display("FAIL full[%0d] full flag got %b expected %b", i, full, e.cn == 3'd4);
            end
            n_assert++;
            if (dut.count !== e.cn || (dut.state_reg == RECOVER) !== e.rc) begin
                n_fail++; $display("FAIL full[%0d] count/recover got %0d/%b expected %0d/%b", i, dut.count, dut.state_reg == RECOVER, e.cn, e.rc);
            end
        end
    endtask

    task automatic test_underflow_and_reset();
        stim_t tbl[$];
        stim_t e;
        tbl.push_back(mk(0,1,1,1,0,32'hA00,32'hA40,0,0,5'b00000,32'h0,3'd0,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,1,1,5'b00000,32'h0,3'd0,1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,0,0,5'b00000,32'h0,3'd0,1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,0,0,5'b00000,32'h0,3'd0,1,0));
        tbl.push_back(mk(1,0,0,0,0,32'h0,32'h0,0,0,5'b00000,32'h0,3'd0,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,0,0,5'b00000,32'h0,3'd0,0,0));
        tbl.push_back(mk(0,1,0,0,0,32'h900,32'h940,0,0,5'b00000,32'h0,3'd1,0,0));
        tbl.push_back(mk(1,0,0,0,0,32'h0,32'h0,1,1,5'b00000,32'h0,3'd0,0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,32'h0,0,0,5'b00000,32'h0,3'd0,0,0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            tick();
            e = exp_q.pop_front();
            n_assert++;
            if ({upd_valid,upd_dir,upd_inc,flushBranch,PCBPUSrc} !== e.ex) begin
                n_fail++; $display("FAIL underflow[%0d] strobes got %b expected %b", i, {upd_valid,upd_dir,upd_inc,flushBranch,PCBPUSrc}, e.ex);
            end
            n_assert++;
            if (underflow_err !== e.uf) begin
                n_fail++; $display("FAIL underflow[%0d] underflow_err got %b expected %b", i, underflow_err, e.uf);
            end
            if (e.r) begin
                n_assert++;
                if (redirect_pc !== e.rd) begin
                    n_fail++; $display("FAIL underflow[%0d] redirect_pc after reset got %h expected %h", i, redirect_pc, e.rd);
                end
            end
            n_assert++;
            if (dut.count !== e.cn || (dut.state_reg == RECOVER) !== e.rc) begin
                n_fail++; $display("FAIL underflow[%0d] count/recover got %0d/%b expected %0d/%b", i, dut.count, dut.state_reg == RECOVER, e.cn, e.rc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_correct_and_mispredict();
        test_flush_queue();
        test_full_back_to_back();
        test_underflow_and_reset();
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard leftover entries got %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Tracks in-flight conditional-branch predictions from fetch until they resolve in execute, in program order. Compares each resolution against the stored prediction and drives the pipeline flush, the PC redirect and the predictor counter-update handshake. Sits between the fetch-stage predictor, the execute-stage branch comparator and the hazard unit. Sequences when predictor state may be updated and when the PC mux must take the recovery address.

Parameters:
DATA_WIDTH, 32, address/PC width
DEPTH, 4, maximum in-flight branches; power of two, at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pred_valid  in  1  fetch-stage branch predicted this cycle
pred_taken  in  1  predicted outcome (1 = taken)
pred_dir  in  1  branch direction (0 = forward, 1 = backward)
pred_pc  in  DATA_WIDTH  PC of the branch
pred_target  in  DATA_WIDTH  computed branch target
stallF  in  1  fetch stalled; suppresses push
BranchE  in  1  branch resolving in execute this cycle
ZeroE  in  1  actual outcome (1 = taken)
full  out  1  queue full; hazard unit stalls fetch
flushBranch  out  1  flush decode/execute; one-cycle pulse
PCBPUSrc  out  1  select redirect_pc at the PC mux; one-cycle pulse
redirect_pc  out  DATA_WIDTH  recovery PC
upd_valid  out  1  counter update strobe
upd_dir  out  1  which counter to update (0 = forward, 1 = backward)
upd_inc  out  1  1 = saturating increment, 0 = saturating decrement
underflow_err  out  1  sticky; BranchE seen with empty queue

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - queue emptied; count = 0; state = TRACK.
  - All outputs 0. redirect_pc = 0. underflow_err cleared.
  - Reset overrides every simultaneous push or resolve.
- Push:
  - Occurs when pred_valid && !stallF && !full && state == TRACK.
  - Entry {pred_pc, pred_target, pred_dir, pred_taken} is written at the tail.
  - pred_valid while full: the push is dropped. Hazard unit must stall on full, so this is a protocol error.
- Resolve (BranchE = 1, queue not empty):
  - The head entry is compared and popped in the same cycle.
  - Outputs are registered, so the response appears at the next edge (latency 1).
  - upd_valid = 1 and upd_dir = head.dir on every resolve.
  - upd_inc = (head.prediction == ZeroE).
  - Correct prediction: flushBranch = 0 and PCBPUSrc = 0.
  - Mispredict: flushBranch = 1 and PCBPUSrc = 1.
    - redirect_pc = ZeroE ? head.target : head.pc + 4 (modulo 2^DATA_WIDTH).
    - The entire queue is cleared (all younger entries are wrong-path).
    - state -> RECOVER.
- Resolve with empty queue:
  - No pop, no update, no redirect.
  - underflow_err is set and held until reset.
- Simultaneous push and resolve:
  - Correct prediction: push and pop both occur; count unchanged.
  - Mispredict: the push is discarded (wrong-path fetch).
  - Full queue with a resolve in the same cycle: the push is allowed (pop frees a slot). full is computed from count before the edge; the queue never overflows.
- State machine:
  - TRACK: normal operation.
  - RECOVER: lasts exactly one cycle, the cycle in which flush and redirect are asserted. Pushes and BranchE are ignored in RECOVER (both are wrong-path). Always -> TRACK.
- Pointer and count behaviour:
  - Head and tail pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - full = (count == DEPTH).
- Strobes: upd_valid, flushBranch and PCBPUSrc are single-cycle pulses. Never held.

Decomposition:
- branch_pkg holds:
  - typedef branch_info_t (packed): branchAddr, targetAddr, direction, prediction.
  - Constant BRANCH_OPCODE = 7'b1100011.
  - Constant PC_INC = 4.
- branch_info_fifo sub-module:
  - Parameterised DEPTH circular buffer of branch_info_t.
  - Signals: push, pop, clear, head output, count, full, empty.
- Top-level contents: compare logic, TRACK/RECOVER FSM, output registers.

Test Plan:
1. Reset, then push {pc=0x100, tgt=0x80, dir=1, pred=1}; BranchE=1, ZeroE=1 two cycles later -> next cycle upd_valid=1, upd_dir=1, upd_inc=1, flushBranch=0, PCBPUSrc=0, count=0.
2. Push {pc=0x200, tgt=0x240, dir=0, pred=0}; resolve ZeroE=1 -> flushBranch=1, PCBPUSrc=1, redirect_pc=0x240, upd_inc=0; state RECOVER for 1 cycle, then TRACK.
3. Push {pc=0x300, pred=1, tgt=0x2F0}, then push a second branch; resolve the first with ZeroE=0 -> redirect_pc=0x304, queue cleared (count=0), second entry never updates; a push in the RECOVER cycle is ignored.
4. Push 4 branches (DEPTH=4) -> full=1; a 5th pred_valid without a resolve is dropped. A 5th push coinciding with a correct resolve -> accepted, count stays 4.
5. BranchE=1 with an empty queue -> no strobes, underflow_err=1 and it stays 1; rst=1 -> underflow_err=0.
6. Assert rst in the same cycle as a mispredicting resolve -> next cycle flushBranch=0, PCBPUSrc=0, count=0, state TRACK.
